// File: rtl/ex3_pkg.sv
// Package for the serial Excess-3 to BCD/binary decoder.
// Holds the Excess-3 code limits, the controller state type and the
// per-code decode helpers used by the digit decoder.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] EX3_MIN    = 4'h3;
  localparam logic [3:0] EX3_MAX    = 4'hC;

  // Encoding matters: ST_HOLD doubles as out_valid.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } ex3_state_e;

  function automatic logic ex3_is_legal(input logic [3:0] code);
    return (code >= EX3_MIN) && (code <= EX3_MAX);
  endfunction

  // Illegal codes decode to 0 so they contribute nothing to the word.
  function automatic logic [3:0] ex3_to_digit(input logic [3:0] code);
    return ex3_is_legal(code) ? (code - EX3_OFFSET) : 4'd0;
  endfunction

endpackage

// File: rtl/ex3_digit_decode.sv
// Combinational Excess-3 digit decoder.
// Ports:
//   code_i   [3:0]  Excess-3 code, bit3 = MSB
//   digit_o  [3:0]  decimal digit (code-3), 0 for illegal codes
//   legal_o         code is within 4'h3..4'hC
module ex3_digit_decode
  import ex3_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  assign legal_o = ex3_is_legal(code_i);
  assign digit_o = ex3_to_digit(code_i);

endmodule

// File: rtl/ex3_to_bcd_deser.sv
// Serial Excess-3 to BCD/binary deserializer.
// Collects NDIGITS Excess-3 codes (most significant digit first), converts
// each to a decimal digit and presents the finished word as packed BCD plus
// its binary value, with per-digit illegal-code flags, on a valid/ready port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake, in_digit = Excess-3 code
//   out_valid/out_ready output handshake
//   out_bcd           packed BCD, first digit in the top nibble
//   out_bin           binary value of the word
//   out_err           any illegal code in the word
//   out_err_pos       per-digit illegal flag, MSB = first digit
//
// state    | meaning
// ST_ACCUM | no word held, collecting digits
// ST_HOLD  | completed word on out_*, waiting for out_ready
module ex3_to_bcd_deser
  import ex3_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_digit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic [BIN_W-1:0]       out_bin,
  output logic                   out_err,
  output logic [NDIGITS-1:0]     out_err_pos
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

  ex3_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     acc_bcd_q, acc_bcd_d;
  logic [BIN_W-1:0]     acc_bin_q, acc_bin_d;
  logic [NDIGITS-1:0]   acc_err_q, acc_err_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 err_q, err_d;
  logic [NDIGITS-1:0]   err_pos_q, err_pos_d;

  logic [3:0]           code_gated;
  logic [3:0]           dig;
  logic                 legal;
  logic                 accept;
  logic [BCD_W-1:0]     nxt_bcd;
  logic [BIN_W-1:0]     nxt_bin;
  logic [NDIGITS-1:0]   nxt_err;

  // Park the decoder on a legal code when no digit is offered so an
  // undriven in_digit cannot leak into the datapath.
  assign code_gated = in_valid ? in_digit : EX3_MIN;

  ex3_digit_decode u_dec (
    .code_i  (code_gated),
    .digit_o (dig),
    .legal_o (legal)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign nxt_bcd = (acc_bcd_q << 4) | BCD_W'(dig);
  assign nxt_bin = (acc_bin_q * BIN_W'(10)) + BIN_W'(dig);
  assign nxt_err = (acc_err_q << 1) | NDIGITS'(!legal);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_bcd_d = acc_bcd_q;
    acc_bin_d = acc_bin_q;
    acc_err_d = acc_err_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    err_d     = err_q;
    err_pos_d = err_pos_q;

    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        // Completing digit: publish the word and restart; a word consumed
        // this same cycle is simply replaced, so HOLD is kept.
        bcd_d     = nxt_bcd;
        bin_d     = nxt_bin;
        err_pos_d = nxt_err;
        err_d     = |nxt_err;
        acc_bcd_d = '0;
        acc_bin_d = '0;
        acc_err_d = '0;
        cnt_d     = '0;
        state_d   = ST_HOLD;
      end else begin
        acc_bcd_d = nxt_bcd;
        acc_bin_d = nxt_bin;
        acc_err_d = nxt_err;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = ST_ACCUM;
      end
    end else if (out_valid && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      acc_bcd_q <= '0;
      acc_bin_q <= '0;
      acc_err_q <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      err_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_bcd_q <= acc_bcd_d;
      acc_bin_q <= acc_bin_d;
      acc_err_q <= acc_err_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
      err_pos_q <= err_pos_d;
    end
  end

  assign out_bcd     = bcd_q;
  assign out_bin     = bin_q;
  assign out_err     = err_q;
  assign out_err_pos = err_pos_q;

endmodule

// File: tb/tb_ex3_to_bcd_deser.sv
module tb_ex3_to_bcd_deser;

  localparam int N     = 4;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             out_valid;
  logic             out_ready;
  logic [4*N-1:0]   out_bcd;
  logic [BIN_W-1:0] out_bin;
  logic             out_err;
  logic [N-1:0]     out_err_pos;

  ex3_to_bcd_deser #(.NDIGITS(N), .BIN_W(BIN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_digit    (in_digit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_bin     (out_bin),
    .out_err     (out_err),
    .out_err_pos (out_err_pos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a held word plus the list of codes received so far.
  int        m_codes[$];
  bit        m_valid = 0;
  longint    m_bcd = 0, m_bin = 0, m_err = 0, m_pos = 0;
  int        words = 0;

  typedef struct {
    logic [15:0] codes;  // first code in [15:12]
    logic [15:0] bcd;
    int          bin;
    logic        err;
    logic [3:0]  pos;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word value from the decimal rules: each legal code is worth code-3,
  // illegal codes are worth 0 and flag their position.
  task automatic model_build();
    m_bcd = 0; m_bin = 0; m_pos = 0;
    for (int i = 0; i < N; i++) begin
      int c, d;
      c = m_codes[i];
      d = (c >= 3 && c <= 12) ? c - 3 : 0;
      if (!(c >= 3 && c <= 12)) m_pos += (64'd1 << (N - 1 - i));
      m_bin = m_bin * 10 + d;
      m_bcd += longint'(d) << (4 * (N - 1 - i));
    end
    m_err = (m_pos != 0) ? 1 : 0;
  endtask

  task automatic model_edge();
    bit acc;
    if (rst) begin
      m_codes.delete();
      m_valid = 0; m_bcd = 0; m_bin = 0; m_err = 0; m_pos = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 0;
      if (acc) begin
        m_codes.push_back(int'(in_digit));
        if (m_codes.size() == N) begin
          model_build();
          m_codes.delete();
          m_valid = 1;
          words++;
        end
      end
    end
  endtask

  // One clock: check in_ready before the edge, update model, check after.
  task automatic cycle();
    bit was_rst;
    #1;
    if (!rst) chk("in_ready", in_ready, (!m_valid || out_ready) ? 1 : 0);
    @(posedge clk);
    was_rst = rst;
    model_edge();
    #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid || was_rst) begin
      chk("out_bcd", out_bcd, m_bcd);
      chk("out_bin", out_bin, m_bin);
      chk("out_err", out_err, m_err);
      chk("out_err_pos", out_err_pos, m_pos);
    end
  endtask

  task automatic send(input logic [3:0] code);
    in_valid = 1'b1;
    in_digit = code;
    cycle();
  endtask

  initial begin
    vecs[0] = '{16'h4567, 16'h1234, 1234, 1'b0, 4'b0000};
    vecs[1] = '{16'hCCCC, 16'h9999, 9999, 1'b0, 4'b0000};
    vecs[2] = '{16'h3333, 16'h0000, 0,    1'b0, 4'b0000};
    vecs[3] = '{16'h4F3C, 16'h1009, 1009, 1'b1, 4'b0100};
    vecs[4] = '{16'h012D, 16'h0000, 0,    1'b1, 4'b1111};
    vecs[5] = '{16'hC3E8, 16'h9005, 9005, 1'b1, 4'b0010};

    rst = 1'b1; in_valid = 1'b0; in_digit = 4'h0; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bcd", out_bcd, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, back-to-back digits, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      logic [15:0] cw;
      cw = vecs[v].codes;
      for (int k = 0; k < N; k++) send(cw[15 - 4*k -: 4]);
      chk("vec_valid", out_valid, 1);
      chk("vec_bcd", out_bcd, vecs[v].bcd);
      chk("vec_bin", out_bin, vecs[v].bin);
      chk("vec_err", out_err, vecs[v].err);
      chk("vec_pos", out_err_pos, vecs[v].pos);
      in_valid = 1'b0;
      cycle();
      chk("vec_valid_1cyc", out_valid, 0);
    end

    // Backpressure: word held while consumer stalls with a digit pending.
    out_ready = 1'b0;
    send(4'h8); send(4'h9); send(4'hA); send(4'hB);
    chk("bp_valid", out_valid, 1);
    in_valid = 1'b1; in_digit = 4'h4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      cycle();
      chk("bp_bcd_stable", out_bcd, 16'h5678);
      chk("bp_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    cycle();
    chk("bp_consumed", out_valid, 0);
    send(4'h5); send(4'h6); send(4'h7);
    chk("bp_next_bcd", out_bcd, 16'h1234);
    in_valid = 1'b0;
    cycle();

    // Partial word discarded by reset.
    send(4'hC); send(4'hC);
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    send(4'h5); send(4'h6); send(4'h7); send(4'h8);
    chk("partial_bcd", out_bcd, 16'h2345);
    chk("partial_err", out_err, 0);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_digit  = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    chk("random_words_seen", (words > 100) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
